// File: rtl/dds_pkg.sv
// Shared definitions for the multichannel DDS: quarter-wave table generator,
// quadrant decode and amplitude constants.
package dds_pkg;

  localparam real PI        = 3.14159265358979323846;
  localparam int  AMP_W_DEF = 16;

  typedef struct packed {
    logic mirror;  // read the table backwards (odd quadrants)
    logic negate;  // negate the table value (lower half-wave)
  } fold_t;

  function automatic int amp_unity(input int amp_w);
    return 1 << (amp_w - 1);
  endfunction

  // Half-step offset keeps lut[k] and lut[~k] exact mirrors of each other.
  function automatic int lut_entry(input int k, input int addr_w, input int out_w);
    real ph;
    real pk;
    ph = (real'(k) + 0.5) * PI / real'(2 << addr_w);
    pk = real'((1 << (out_w - 1)) - 1);
    return $rtoi($sin(ph) * pk + 0.5);
  endfunction

  function automatic fold_t fold_quadrant(input logic [1:0] q);
    fold_t f;
    f.mirror = q[0];
    f.negate = q[1];
    return f;
  endfunction

  localparam int AMP_UNITY = amp_unity(AMP_W_DEF);

endpackage

// File: rtl/dds_quarter_lut.sv
// Quarter-wave sine ROM with one cycle of read latency, shared by all channels.
module dds_quarter_lut
  import dds_pkg::*;
#(
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 16
) (
  input  logic                  i_clk,
  input  logic [LUT_ADDR_W-1:0] i_addr,
  output logic [OUT_W-2:0]      o_data
);

  logic [OUT_W-2:0] rom [2**LUT_ADDR_W];

  for (genvar k = 0; k < 2**LUT_ADDR_W; k++) begin : g_rom
    assign rom[k] = (OUT_W-1)'(lut_entry(k, LUT_ADDR_W, OUT_W));
  end

  always_ff @(posedge i_clk) begin
    o_data <= rom[i_addr];
  end

endmodule

// File: rtl/dds_multichannel_gen.sv
// Time-multiplexed N-channel DDS: one slot per cycle, shared quarter-wave LUT,
// frame-coherent config updates through per-channel shadow registers.
module dds_multichannel_gen
  import dds_pkg::*;
#(
  parameter int  N_CH       = 4,
  parameter int  PHASE_W    = 32,
  parameter int  LUT_ADDR_W = 10,
  parameter int  OUT_W      = 16,
  parameter int  AMP_W      = AMP_W_DEF,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [CH_W-1:0]         i_cfg_ch,
  input  logic [PHASE_W-1:0]      i_cfg_phase_inc,
  input  logic [PHASE_W-1:0]      i_cfg_phase_ofs,
  input  logic [AMP_W-1:0]        i_cfg_amp,
  input  logic                    i_cfg_clr,
  output logic                    o_sample_valid,
  output logic [CH_W-1:0]         o_sample_ch,
  output logic signed [OUT_W-1:0] o_sample
);

  localparam int PW2    = LUT_ADDR_W + 2;
  localparam int SHIFT  = PHASE_W - PW2;
  localparam int PROD_W = OUT_W + AMP_W + 1;
  localparam logic [AMP_W-1:0]         UNITY = AMP_W'(amp_unity(AMP_W));
  localparam logic signed [PROD_W-1:0] HALF  = PROD_W'(1) << (AMP_W - 2);

  logic [CH_W-1:0]    slot;
  logic               rdy_q;
  logic [PHASE_W-1:0] acc    [N_CH];
  logic [PHASE_W-1:0] inc    [N_CH];
  logic [PHASE_W-1:0] ofs    [N_CH];
  logic [AMP_W-1:0]   amp    [N_CH];
  logic [PHASE_W-1:0] sh_inc [N_CH];
  logic [PHASE_W-1:0] sh_ofs [N_CH];
  logic [AMP_W-1:0]   sh_amp [N_CH];
  logic [N_CH-1:0]    sh_clr;
  logic [N_CH-1:0]    pending;

  logic               apply, cfg_fire, use_sh;
  logic [PHASE_W-1:0] inc_eff, ofs_eff, acc_eff;
  logic [AMP_W-1:0]   amp_eff;

  assign apply       = i_enable && (slot == '0);
  assign o_cfg_ready = rdy_q && !apply;
  assign cfg_fire    = i_cfg_valid && o_cfg_ready && (32'(i_cfg_ch) < N_CH);

  // Slot 0 on the apply cycle must already see the shadow values it is applying.
  always_comb begin
    use_sh  = apply && pending[slot];
    inc_eff = use_sh ? sh_inc[slot] : inc[slot];
    ofs_eff = use_sh ? sh_ofs[slot] : ofs[slot];
    amp_eff = use_sh ? sh_amp[slot] : amp[slot];
    acc_eff = (use_sh && sh_clr[slot]) ? '0 : acc[slot];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot    <= '0;
      rdy_q   <= 1'b0;
      sh_clr  <= '0;
      pending <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        acc[c]    <= '0;
        inc[c]    <= '0;
        ofs[c]    <= '0;
        amp[c]    <= UNITY;
        sh_inc[c] <= '0;
        sh_ofs[c] <= '0;
        sh_amp[c] <= UNITY;
      end
    end else begin
      rdy_q <= 1'b1;
      if (cfg_fire) begin
        sh_inc[i_cfg_ch]  <= i_cfg_phase_inc;
        sh_ofs[i_cfg_ch]  <= i_cfg_phase_ofs;
        sh_amp[i_cfg_ch]  <= (i_cfg_amp > UNITY) ? UNITY : i_cfg_amp;
        sh_clr[i_cfg_ch]  <= i_cfg_clr;
        pending[i_cfg_ch] <= 1'b1;
      end
      if (apply) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
          if (pending[c]) begin
            inc[c] <= sh_inc[c];
            ofs[c] <= sh_ofs[c];
            amp[c] <= sh_amp[c];
            if (sh_clr[c]) acc[c] <= '0;
          end
        end
        pending <= '0;
      end
      if (i_enable) begin
        acc[slot] <= acc_eff + inc_eff;
        slot      <= (slot == CH_W'(N_CH - 1)) ? '0 : slot + 1'b1;
      end
    end
  end

  logic                    v1, v2, v3;
  logic [CH_W-1:0]         ch1, ch2, ch3;
  logic [AMP_W-1:0]        amp1, amp2, amp3;
  logic [PW2-1:0]          ph1;
  logic                    neg2;
  logic signed [OUT_W-1:0] s3;
  fold_t                   fq;
  logic [LUT_ADDR_W-1:0]   lut_addr;
  logic [OUT_W-2:0]        lut_q;
  logic signed [OUT_W-1:0] lut_s;
  logic signed [PROD_W-1:0] prod, rnd;

  assign fq       = fold_quadrant(ph1[PW2-1 -: 2]);
  assign lut_addr = fq.mirror ? ~ph1[LUT_ADDR_W-1:0] : ph1[LUT_ADDR_W-1:0];
  assign lut_s    = $signed({1'b0, lut_q});
  assign prod     = PROD_W'(s3) * PROD_W'($signed({1'b0, amp3}));
  assign rnd      = prod + HALF;

  dds_quarter_lut #(
    .LUT_ADDR_W(LUT_ADDR_W),
    .OUT_W     (OUT_W)
  ) u_lut (
    .i_clk (i_clk),
    .i_addr(lut_addr),
    .o_data(lut_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      ch1 <= '0; ch2 <= '0; ch3 <= '0;
      amp1 <= '0; amp2 <= '0; amp3 <= '0;
      ph1 <= '0;
      neg2 <= 1'b0;
      s3 <= '0;
      o_sample_valid <= 1'b0;
      o_sample_ch    <= '0;
      o_sample       <= '0;
    end else begin
      v1   <= i_enable;
      ch1  <= slot;
      amp1 <= amp_eff;
      ph1  <= PW2'((acc_eff + ofs_eff) >> SHIFT);
      v2   <= v1;
      ch2  <= ch1;
      amp2 <= amp1;
      neg2 <= fq.negate;
      v3   <= v2;
      ch3  <= ch2;
      amp3 <= amp2;
      s3   <= neg2 ? -lut_s : lut_s;
      o_sample_valid <= v3;
      o_sample_ch    <= ch3;
      o_sample       <= OUT_W'(rnd >>> (AMP_W - 1));
    end
  end

endmodule

// File: tb/tb_dds_multichannel_gen.sv
// Bench for dds_multichannel_gen: directed vector table plus randomized traffic
// scored against a sample-level reference model.
module tb_dds_multichannel_gen;
  import dds_pkg::*;

  localparam int N_CH = 4, PHASE_W = 32, LUT_ADDR_W = 10, OUT_W = 16, AMP_W = 16;
  localparam int CH_W = 2;
  localparam int UNITY = AMP_UNITY;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, cfg_valid = 1'b0, cfg_clr = 1'b0;
  logic cfg_ready, s_valid;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [CH_W-1:0] s_ch;
  logic [31:0] cfg_inc = '0, cfg_ofs = '0;
  logic [15:0] cfg_amp = '0;
  logic signed [15:0] s_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_multichannel_gen #(
    .N_CH(N_CH), .PHASE_W(PHASE_W), .LUT_ADDR_W(LUT_ADDR_W), .OUT_W(OUT_W), .AMP_W(AMP_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_ch(cfg_ch),
    .i_cfg_phase_inc(cfg_inc), .i_cfg_phase_ofs(cfg_ofs), .i_cfg_amp(cfg_amp),
    .i_cfg_clr(cfg_clr),
    .o_sample_valid(s_valid), .o_sample_ch(s_ch), .o_sample(s_val)
  );

  // Full-wave sine sampled at bin centres, then amplitude scaling with round-half-up.
  function automatic int exp_sample(input logic [31:0] phase, input int a);
    int p;
    real v;
    int s;
    longint pr;
    p  = int'(phase >> (PHASE_W - LUT_ADDR_W - 2));
    v  = $sin((real'(p) + 0.5) * 2.0 * PI / real'(1 << (LUT_ADDR_W + 2)))
         * real'((1 << (OUT_W - 1)) - 1);
    s  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    pr = longint'(s) * longint'(a) + longint'(1 << (AMP_W - 2));
    return int'(pr >>> (AMP_W - 1));
  endfunction

  typedef struct { int due; int ch; int val; } exp_t;
  typedef struct { int ch; int val; } log_t;
  exp_t exp_q[$];
  log_t log_q[$];

  logic [31:0] m_acc[N_CH], m_inc[N_CH], m_ofs[N_CH], m_sinc[N_CH], m_sofs[N_CH];
  int  m_amp[N_CH], m_samp[N_CH];
  bit  m_sclr[N_CH], m_pend[N_CH];
  int  m_slot = 0;
  bit  m_rdy = 1'b0;
  int  cyc = 0;

  task automatic m_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_acc[c] = '0; m_inc[c] = '0; m_ofs[c] = '0; m_amp[c] = UNITY;
      m_pend[c] = 1'b0;
    end
    m_slot = 0;
    m_rdy  = 1'b0;
    exp_q.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit apply;
    int a;
    if (!rst_n) begin
      m_reset();
    end else begin
      cyc++;
      apply = en && (m_slot == 0);
      if (cfg_valid && m_rdy && !apply && int'(cfg_ch) < N_CH) begin
        a = int'(cfg_amp);
        m_sinc[cfg_ch] = cfg_inc;
        m_sofs[cfg_ch] = cfg_ofs;
        m_samp[cfg_ch] = (a > UNITY) ? UNITY : a;
        m_sclr[cfg_ch] = cfg_clr;
        m_pend[cfg_ch] = 1'b1;
      end
      if (apply) begin
        for (int c = 0; c < N_CH; c++) begin
          if (m_pend[c]) begin
            m_inc[c] = m_sinc[c]; m_ofs[c] = m_sofs[c]; m_amp[c] = m_samp[c];
            if (m_sclr[c]) m_acc[c] = '0;
          end
          m_pend[c] = 1'b0;
        end
      end
      if (en) begin
        exp_q.push_back('{due: cyc + 3, ch: m_slot,
                          val: exp_sample(m_acc[m_slot] + m_ofs[m_slot], m_amp[m_slot])});
        m_acc[m_slot] = m_acc[m_slot] + m_inc[m_slot];
        m_slot = (m_slot + 1) % N_CH;
      end
      m_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (s_valid) begin
      log_q.push_back('{ch: int'(s_ch), val: int'(s_val)});
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected cyc=%0d got ch=%0d val=%0d required=no sample",
                 cyc, s_ch, s_val);
      end else begin
        e = exp_q.pop_front();
        if (e.due != cyc || e.ch != int'(s_ch) || e.val != int'(s_val)) begin
          errors++;
          $display("FAIL sample cyc=%0d got ch=%0d val=%0d required cyc=%0d ch=%0d val=%0d",
                   cyc, s_ch, s_val, e.due, e.ch, e.val);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL sample_missing cyc=%0d got none required ch=%0d val=%0d", cyc, e.ch, e.val);
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  // Called at a falling edge; returns at a falling edge after acceptance.
  task automatic cfg_write(input int ch, input logic [31:0] inc, input logic [31:0] ofs,
                           input int a, input bit clr);
    bit done;
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_inc = inc; cfg_ofs = ofs;
    cfg_amp = 16'(a); cfg_clr = clr;
    done = 1'b0;
    for (int n = 0; n < 16 && !done; n++) begin
      #1 done = cfg_ready;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    check("cfg_accept_timeout", int'(done), 1);
  endtask

  typedef struct {
    int ch; bit dbl;
    logic [31:0] inc0; logic [31:0] inc; logic [31:0] ofs;
    int amp;
    logic [0:3][15:0] exp;
  } vec_t;

  function automatic vec_t mk(input int ch, input bit dbl, input logic [31:0] inc0,
                              input logic [31:0] inc, input logic [31:0] ofs, input int a,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.ch = ch; v.dbl = dbl; v.inc0 = inc0; v.inc = inc; v.ofs = ofs; v.amp = a;
    v.exp[0] = 16'(e0); v.exp[1] = 16'(e1); v.exp[2] = 16'(e2); v.exp[3] = 16'(e3);
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    int bad, n, r;
    logic [31:0] ri, ro;

    vecs[0] = mk(0, 0, 0, 32'h4000_0000, 0, UNITY, 25, 32767, -25, -32767);
    vecs[1] = mk(1, 0, 0, 0, 32'h4000_0000, UNITY, 32767, 32767, 32767, 32767);
    vecs[2] = mk(1, 0, 0, 0, 32'h4000_0000, 16384, 16384, 16384, 16384, 16384);
    vecs[3] = mk(3, 0, 0, 32'h8000_0000, 0, UNITY, 25, -25, 25, -25);
    vecs[4] = mk(2, 0, 0, 32'h4000_0000, 32'h8000_0000, 16'hFFFF, -25, -32767, 25, 32767);
    vecs[5] = mk(0, 0, 0, 0, 0, 16384, 13, 13, 13, 13);
    vecs[6] = mk(1, 0, 0, 0, 32'h8000_0000, 16384, -12, -12, -12, -12);
    vecs[7] = mk(2, 1, 32'h1000_0000, 32'h2000_0000, 0, UNITY,
                 25, exp_sample(32'h2000_0000, UNITY), 32767, exp_sample(32'h6000_0000, UNITY));

    rst_n = 1'b0;
    tick(3);
    check("rst_valid", int'(s_valid), 0);
    check("rst_sample", int'(s_val), 0);
    check("rst_ch", int'(s_ch), 0);
    check("rst_ready", int'(cfg_ready), 0);
    rst_n = 1'b1;
    #1 check("ready_at_release", int'(cfg_ready), 0);
    @(negedge clk);
    check("ready_after_release", int'(cfg_ready), 1);

    log_q.delete();
    en = 1'b1; tick(16); en = 1'b0; tick(6);
    check("default_count", log_q.size(), 16);
    bad = 0;
    foreach (log_q[i]) if (log_q[i].val != 25 || log_q[i].ch != i % N_CH) bad++;
    check("default_values", bad, 0);

    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].dbl) cfg_write(vecs[i].ch, vecs[i].inc0, vecs[i].ofs, vecs[i].amp, 1'b1);
      cfg_write(vecs[i].ch, vecs[i].inc, vecs[i].ofs, vecs[i].amp, 1'b1);
      log_q.delete();
      en = 1'b1; tick(4 * N_CH + 4); en = 1'b0; tick(6);
      n = 0;
      foreach (log_q[j]) begin
        if (log_q[j].ch == vecs[i].ch && n < 4) begin
          check($sformatf("vec%0d_s%0d", i, n), log_q[j].val, int'($signed(vecs[i].exp[n])));
          n++;
        end
      end
      check($sformatf("vec%0d_count", i), n, 4);
    end

    // Double write landing mid-frame while paused: only the last one applies.
    do_reset();
    en = 1'b1; tick(6); en = 1'b0;
    cfg_write(2, 32'h1000_0000, 0, UNITY, 1'b0);
    cfg_write(2, 32'h2000_0000, 0, UNITY, 1'b0);
    en = 1'b1; tick(20); en = 1'b0; tick(6);

    // Enable gap: exactly the four in-flight samples drain.
    do_reset();
    cfg_write(0, 32'h4000_0000, 0, UNITY, 1'b1);
    cfg_write(3, 32'h00BC_614E, 32'h1234_5678, 20000, 1'b1);
    en = 1'b1; tick(10);
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      #1 n += int'(s_valid);
      @(negedge clk);
    end
    check("drain_count", n, 4);
    en = 1'b1; tick(20); en = 1'b0; tick(6);

    // Asynchronous reset with a pending write.
    en = 1'b1; tick(5);
    cfg_write(1, 32'h4000_0000, 32'h2000_0000, 1000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(s_valid), 0);
    check("midrst_sample", int'(s_val), 0);
    check("midrst_ch", int'(s_ch), 0);
    check("midrst_ready", int'(cfg_ready), 0);
    @(negedge clk);
    en = 1'b0; tick(2);
    rst_n = 1'b1;
    log_q.delete();
    en = 1'b1; tick(16); en = 1'b0; tick(6);
    check("postrst_count", log_q.size(), 16);
    bad = 0;
    foreach (log_q[i]) if (log_q[i].val != 25) bad++;
    check("postrst_values", bad, 0);

    // Randomized traffic, scored by the monitor.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        r  = $urandom_range(0, 3);
        ri = (r == 0) ? 32'($urandom_range(0, 4096)) << 20 : $urandom();
        ro = $urandom();
        cfg_write($urandom_range(0, N_CH - 1), ri, ro,
                  (r == 1) ? $urandom_range(32768, 65535) : $urandom_range(0, 32768),
                  1'($urandom_range(0, 1)));
      end else begin
        tick(1);
      end
    end
    en = 1'b0; tick(8);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
